// File: rtl/digit_serial_adder_pkg.sv
// Shared constants and FSM state type for the digit-serial adder.
// Used by digit_serial_adder and its digit stage.
package digit_serial_pkg;

  localparam int DIGIT_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/digit_add2.sv
// Two-bit full adder: one digit of the serial addition, carry in and out.
module digit_add2
  import digit_serial_pkg::*;
(
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               cin,
  output logic [DIGIT_W-1:0] s,
  output logic               cout
);

  logic [DIGIT_W:0] sum;

  always_comb begin
    sum  = {1'b0, a} + {1'b0, b} + {{DIGIT_W{1'b0}}, cin};
    s    = sum[DIGIT_W-1:0];
    cout = sum[DIGIT_W];
  end

endmodule

// File: rtl/digit_serial_adder.sv
// Adds two WIDTH-bit operands two bits per clock, LSB digit first.
// Define DIGIT_SERIAL_ADDER_SUB_EN to add a 'sub' port selecting p + ~q + 1.
module digit_serial_adder
  import digit_serial_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] p,
  input  logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   r
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
  ,
  input  logic             sub
`endif
);

  localparam int N     = WIDTH / DIGIT_W;
  localparam int CNT_W = $clog2(N + 1);
  localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(N - 1);

  state_t             state;
  state_t             state_next;
  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic               carry;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH:0]     r_reg;
  logic [CNT_W:0]     idx;
  logic [DIGIT_W-1:0] a_digit;
  logic [DIGIT_W-1:0] b_digit;
  logic [DIGIT_W-1:0] s_digit;
  logic               cout;
  logic               carry_init;

`ifdef DIGIT_SERIAL_ADDER_SUB_EN
  logic sub_reg;

  always_ff @(posedge clk) begin
    if (rst)
      sub_reg <= 1'b0;
    else if (state == IDLE && start)
      sub_reg <= sub;
  end

  assign carry_init = sub;
  // Subtraction inverts each B digit; the +1 comes from the initial carry.
  assign b_digit    = sub_reg ? ~b_reg[idx +: DIGIT_W] : b_reg[idx +: DIGIT_W];
`else
  assign carry_init = 1'b0;
  assign b_digit    = b_reg[idx +: DIGIT_W];
`endif

  assign idx     = {cnt, 1'b0};
  assign a_digit = a_reg[idx +: DIGIT_W];

  digit_add2 u_digit (
    .a    (a_digit),
    .b    (b_digit),
    .cin  (carry),
    .s    (s_digit),
    .cout (cout)
  );

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (cnt == LAST_DIGIT) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg <= '0;
      b_reg <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      r_reg <= '0;
    end else if (state == IDLE && start) begin
      a_reg <= p;
      b_reg <= q;
      carry <= carry_init;
      cnt   <= '0;
      r_reg <= '0;
    end else if (state == RUN) begin
      r_reg[idx +: DIGIT_W] <= s_digit;
      carry                 <= cout;
      if (cnt == LAST_DIGIT)
        r_reg[WIDTH] <= cout;
      else
        cnt <= cnt + CNT_W'(1);
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);
  assign r    = r_reg;

endmodule
